// File: rtl/gemm_loop_controller.sv
// Loop-nest sequencer for the single-MAC GEMM datapath.
// Walks m (outer), n (middle), k (inner) and issues one point per RUN cycle.
// A/B read addresses are built incrementally from registered counters.
// MAC strobes and the C write are delayed to line up with the one-cycle SRAM
// read latency. Every output comes straight from a flop.
module gemm_loop_controller #(
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     mac_en_o,
  output logic                     mac_clr_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [SizeAddrWidth-1:0] SizeZero = {SizeAddrWidth{1'b0}};
  localparam logic [SizeAddrWidth-1:0] SizeOne  = {{(SizeAddrWidth-1){1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0]     AddrZero = {AddrWidth{1'b0}};
  localparam logic [AddrWidth-1:0]     AddrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};

  state_e                   state_r, state_s;
  logic [SizeAddrWidth-1:0] m_size_r, k_size_r, n_size_r;
  logic [SizeAddrWidth-1:0] m_size_s, k_size_s, n_size_s;
  logic [SizeAddrWidth-1:0] m_r, n_r, k_r, m_s, n_s, k_s;
  logic [AddrWidth-1:0]     row_base_r, row_base_s;   // m*K
  logic [AddrWidth-1:0]     a_addr_r, a_addr_s;
  logic [AddrWidth-1:0]     b_addr_r, b_addr_s;
  logic [AddrWidth-1:0]     c_idx_r, c_idx_s;         // m*N+n
  logic                     drain_r, drain_s;

  // Pipeline stage 1 (data arriving from SRAM) and stage 2 (C write).
  logic                     en1_r, clr1_r, wr1_r;
  logic [AddrWidth-1:0]     waddr1_r;
  logic                     we_r;
  logic [AddrWidth-1:0]     c_addr_r;
  logic                     busy_r, done_r;

  logic                     issue_s, last_k_s, last_n_s, last_m_s;
  logic [AddrWidth-1:0]     k_ext_s, n_ext_s;

  assign issue_s  = (state_r == RUN);
  assign last_k_s = (k_r == (k_size_r - SizeOne));
  assign last_n_s = (n_r == (n_size_r - SizeOne));
  assign last_m_s = (m_r == (m_size_r - SizeOne));
  assign k_ext_s  = AddrWidth'(k_size_r);
  assign n_ext_s  = AddrWidth'(n_size_r);

  // Next-state and loop-counter / address update logic.
  always_comb begin
    state_s    = state_r;
    m_size_s   = m_size_r;
    k_size_s   = k_size_r;
    n_size_s   = n_size_r;
    m_s        = m_r;
    n_s        = n_r;
    k_s        = k_r;
    row_base_s = row_base_r;
    a_addr_s   = a_addr_r;
    b_addr_s   = b_addr_r;
    c_idx_s    = c_idx_r;
    drain_s    = drain_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          m_size_s   = M_size_i;
          k_size_s   = K_size_i;
          n_size_s   = N_size_i;
          m_s        = SizeZero;
          n_s        = SizeZero;
          k_s        = SizeZero;
          row_base_s = AddrZero;
          a_addr_s   = AddrZero;
          b_addr_s   = AddrZero;
          c_idx_s    = AddrZero;
          drain_s    = 1'b0;
          if ((M_size_i == SizeZero) || (K_size_i == SizeZero) || (N_size_i == SizeZero)) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_k_s) begin
          k_s     = SizeZero;
          c_idx_s = c_idx_r + AddrOne;
          if (last_n_s) begin
            n_s = SizeZero;
            if (last_m_s) begin
              // Final point issued: park addresses at 0 and drain the pipe.
              m_s      = SizeZero;
              a_addr_s = AddrZero;
              b_addr_s = AddrZero;
              drain_s  = 1'b0;
              state_s  = DRAIN;
            end else begin
              m_s        = m_r + SizeOne;
              row_base_s = row_base_r + k_ext_s;
              a_addr_s   = row_base_r + k_ext_s;
              b_addr_s   = AddrZero;
            end
          end else begin
            n_s      = n_r + SizeOne;
            a_addr_s = row_base_r;
            b_addr_s = AddrWidth'(n_r) + AddrOne;
          end
        end else begin
          k_s      = k_r + SizeOne;
          a_addr_s = a_addr_r + AddrOne;
          b_addr_s = b_addr_r + n_ext_s;
        end
      end
      DRAIN: begin
        if (drain_r) begin
          state_s = DONE;
        end else begin
          drain_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched sizes, loop counters and A/B address registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      m_size_r   <= SizeZero;
      k_size_r   <= SizeZero;
      n_size_r   <= SizeZero;
      m_r        <= SizeZero;
      n_r        <= SizeZero;
      k_r        <= SizeZero;
      row_base_r <= AddrZero;
      a_addr_r   <= AddrZero;
      b_addr_r   <= AddrZero;
      c_idx_r    <= AddrZero;
      drain_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      m_size_r   <= m_size_s;
      k_size_r   <= k_size_s;
      n_size_r   <= n_size_s;
      m_r        <= m_s;
      n_r        <= n_s;
      k_r        <= k_s;
      row_base_r <= row_base_s;
      a_addr_r   <= a_addr_s;
      b_addr_r   <= b_addr_s;
      c_idx_r    <= c_idx_s;
      drain_r    <= drain_s;
    end
  end

  // Two-stage strobe pipeline aligning MAC and C write to SRAM read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en1_r    <= 1'b0;
      clr1_r   <= 1'b0;
      wr1_r    <= 1'b0;
      waddr1_r <= AddrZero;
      we_r     <= 1'b0;
      c_addr_r <= AddrZero;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      en1_r    <= issue_s;
      clr1_r   <= issue_s && (k_r == SizeZero);
      wr1_r    <= issue_s && last_k_s;
      waddr1_r <= (issue_s && last_k_s) ? c_idx_r : AddrZero;
      we_r     <= wr1_r;
      c_addr_r <= wr1_r ? waddr1_r : AddrZero;
      busy_r   <= (state_s == RUN) || (state_s == DRAIN);
      done_r   <= (state_s == DONE);
    end
  end

  assign sram_a_addr_o = a_addr_r;
  assign sram_b_addr_o = b_addr_r;
  assign sram_c_addr_o = c_addr_r;
  assign sram_c_we_o   = we_r;
  assign mac_en_o      = en1_r;
  assign mac_clr_o     = clr1_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;

endmodule

// File: tb/tb_gemm_loop_controller.sv
// Directed bench for gemm_loop_controller: per-cycle expected strobes and
// addresses derived from the (m,n,k) loop nest, plus a bench-side SRAM/MAC
// model checked against a directly computed matrix product.
module tb_gemm_loop_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  m_size, k_size, n_size;
  logic [11:0] sram_a_addr, sram_b_addr, sram_c_addr;
  logic        sram_c_we, mac_en, mac_clr, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  int sram_a [0:4095];
  int sram_b [0:4095];
  int sram_c [0:4095];
  int a_rd, b_rd, acc;

  gemm_loop_controller #(.AddrWidth(12), .SizeAddrWidth(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .M_size_i      (m_size),
    .K_size_i      (k_size),
    .N_size_i      (n_size),
    .sram_a_addr_o (sram_a_addr),
    .sram_b_addr_o (sram_b_addr),
    .sram_c_addr_o (sram_c_addr),
    .sram_c_we_o   (sram_c_we),
    .mac_en_o      (mac_en),
    .mac_clr_o     (mac_clr),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side SRAM read port, MAC and C write port driven by DUT strobes.
  always @(posedge clk) begin
    a_rd <= sram_a[sram_a_addr];
    b_rd <= sram_b[sram_b_addr];
    if (mac_en) acc <= (mac_clr ? 0 : acc) + a_rd * b_rd;
    if (sram_c_we) sram_c[sram_c_addr] <= acc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},    32'(sram_a_addr), 32'd0);
    check({tag, "_b"},    32'(sram_b_addr), 32'd0);
    check({tag, "_c"},    32'(sram_c_addr), 32'd0);
    check({tag, "_we"},   32'(sram_c_we),   32'd0);
    check({tag, "_en"},   32'(mac_en),      32'd0);
    check({tag, "_clr"},  32'(mac_clr),     32'd0);
    check({tag, "_busy"}, 32'(busy),        32'd0);
    check({tag, "_done"}, 32'(done),        32'd0);
  endtask

  // Starts a run from an IDLE cycle and checks every output each cycle
  // until done_o; abort > 0 stops early after that cycle (for reset tests).
  task automatic run_check(input int mm, input int kk, input int nn,
                           input bit hold, input bit disturb, input int abort);
    int  total, done_cyc, wcount, idx;
    int  ea, eb, een, eclr, ewe, eca, ebusy, edone;
    bit  zero;
    zero     = (mm == 0) || (kk == 0) || (nn == 0);
    total    = mm * kk * nn;
    done_cyc = zero ? 1 : total + 3;
    wcount   = 0;
    m_size = 8'(mm); k_size = 8'(kk); n_size = 8'(nn);
    start  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= done_cyc; c++) begin
      @(negedge clk);
      ea = 0; eb = 0; een = 0; eclr = 0; ewe = 0; eca = 0;
      if (!zero && c <= total) begin
        idx = c - 1;
        ea = ((idx / (nn * kk)) * kk + idx % kk) % 4096;
        eb = ((idx % kk) * nn + (idx / kk) % nn) % 4096;
      end
      if (!zero && c >= 2 && c <= total + 1) begin
        idx  = c - 2;
        een  = 1;
        eclr = ((idx % kk) == 0) ? 1 : 0;
      end
      if (!zero && c >= 3 && c <= total + 2) begin
        idx = c - 3;
        if ((idx % kk) == kk - 1) begin
          ewe = 1;
          eca = (idx / kk) % 4096;
        end
      end
      ebusy = (!zero && c <= total + 2) ? 1 : 0;
      edone = (c == done_cyc) ? 1 : 0;
      check("a_addr", 32'(sram_a_addr), 32'(ea));
      check("b_addr", 32'(sram_b_addr), 32'(eb));
      check("mac_en", 32'(mac_en),      32'(een));
      check("mac_clr", 32'(mac_clr),    32'(eclr));
      check("c_we",   32'(sram_c_we),   32'(ewe));
      check("c_addr", 32'(sram_c_addr), 32'(eca));
      check("busy",   32'(busy),        32'(ebusy));
      check("done",   32'(done),        32'(edone));
      if (sram_c_we) wcount++;
      if (disturb && c == 10) begin
        start = 1'b1; m_size = 8'd1; k_size = 8'd1; n_size = 8'd1;
      end else if (disturb && c == 11) begin
        start = 1'b0;
      end
      if (abort != 0 && c == abort) return;
    end
    check("wr_count", 32'(wcount), zero ? 32'd0 : 32'(mm * nn));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy),   32'd0);
    check({tag, "_done"}, 32'(done),   32'd0);
    check({tag, "_en"},   32'(mac_en), 32'd0);
  endtask

  initial begin
    int gold;
    rst_n = 1'b0; start = 1'b0;
    m_size = 8'd0; k_size = 8'd0; n_size = 8'd0;
    acc = 0; a_rd = 0; b_rd = 0;
    for (int i = 0; i < 4096; i++) begin
      sram_a[i] = 0; sram_b[i] = 0; sram_c[i] = -99999;
    end
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2x2 reference pattern.
    run_check(2, 2, 2, 1'b0, 1'b0, 0);
    idle_check("idle_222");

    // Single point.
    run_check(1, 1, 1, 1'b0, 1'b0, 0);
    idle_check("idle_111");

    // Zero size: straight to DONE.
    run_check(3, 0, 4, 1'b0, 1'b0, 0);
    idle_check("idle_zero");

    // 4x3x5 with mid-run disturbance and a datapath product check.
    for (int i = 0; i < 12; i++) sram_a[i] = int'($urandom_range(255, 0)) - 128;
    for (int i = 0; i < 15; i++) sram_b[i] = int'($urandom_range(255, 0)) - 128;
    run_check(4, 3, 5, 1'b0, 1'b1, 0);
    idle_check("idle_435");
    for (int m = 0; m < 4; m++) begin
      for (int n = 0; n < 5; n++) begin
        gold = 0;
        for (int k = 0; k < 3; k++) gold += sram_a[m * 3 + k] * sram_b[k * 5 + n];
        check("c_data", 32'(sram_c[m * 5 + n]), 32'(gold));
      end
    end

    // 8x8x8 interrupted by reset at cycle 100.
    run_check(8, 8, 8, 1'b0, 1'b0, 100);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("rst_hold1");
    @(negedge clk);
    check_all_zero("rst_hold2");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");
    run_check(2, 2, 2, 1'b0, 1'b0, 0);
    idle_check("idle_after_rst");

    // Back-to-back with start held high; sizes re-latched per run.
    run_check(2, 1, 3, 1'b1, 1'b0, 0);
    idle_check("b2b_1");
    run_check(1, 2, 2, 1'b1, 1'b0, 0);
    start = 1'b0;
    idle_check("b2b_2");
    idle_check("b2b_3");

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_loop_controller.md
Name: gemm_loop_controller

Overview:
Sequencer for the single-MAC GEMM datapath inside gemm_accelerator_top. It walks the M/N/K loop nest and generates row-major read addresses for SRAM A (MxK) and SRAM B (KxN). It emits enable/clear strobes to the MAC, aligned to the 1-cycle SRAM read latency, and issues the SRAM C write (address and write-enable) once each output element is complete. The MAC and the C write-data path sit outside this block.

Parameters:
AddrWidth, 12, SRAM address width (matches DataDepth 4096).
SizeAddrWidth, 8, width of M/K/N size inputs.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
start_i  in  1  start request; sampled only in IDLE.
M_size_i  in  SizeAddrWidth  rows of A/C.
K_size_i  in  SizeAddrWidth  cols of A / rows of B.
N_size_i  in  SizeAddrWidth  cols of B/C.
sram_a_addr_o  out  AddrWidth  A read address, m*K+k.
sram_b_addr_o  out  AddrWidth  B read address, k*N+n.
sram_c_addr_o  out  AddrWidth  C write address, m*N+n.
sram_c_we_o  out  1  C write enable, one cycle per output element.
mac_en_o  out  1  MAC accumulate enable; SRAM rdata valid this cycle.
mac_clr_o  out  1  with mac_en_o: first product of an element (k==0), MAC loads instead of accumulating.
busy_o  out  1  high in RUN and DRAIN.
done_o  out  1  single-cycle completion pulse.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values: all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE -> RUN when start_i=1 and M, K, N are all nonzero.
  - IDLE -> DONE when start_i=1 and any size is 0. No memory access and no mac_en_o/sram_c_we_o occur.
  - RUN lasts exactly M*N*K cycles, then -> DRAIN.
  - DRAIN lasts 2 cycles, then -> DONE.
  - DONE lasts 1 cycle (done_o=1), then -> IDLE.
- Sizes are latched on the accepted start. Input changes during the run are ignored.
- start_i outside IDLE is ignored (no queueing).
- Loop order: m outer, n middle, k inner. One (m,n,k) point is issued per RUN cycle.
- Addresses are generated incrementally with adders only, no multipliers:
  - a_addr: +1 per k. At k wrap it returns to the row base m*K. At n wrap the row base advances by K.
  - b_addr: +N per k. At k wrap it returns to column n, then to 0 at n wrap.
- Address arithmetic wraps modulo 2^AddrWidth. There is no range check.
- A/B addresses are driven from registered counters during RUN and held at 0 outside RUN.
- Pipeline, with issue cycle t:
  - t+1: mac_en_o=1; mac_clr_o=(k==0).
  - t+2: if k==K-1, sram_c_we_o=1 and sram_c_addr_o=m*N+n (registered, delayed 2 cycles).
  - sram_c_addr_o is 0 when sram_c_we_o=0.
- Latency: start accepted at edge t0. First address at t0+1; last issue at t0+M*N*K; last write at t0+M*N*K+2; done_o at t0+M*N*K+3.
- K=1: mac_clr_o=1 on every mac_en_o, and there is one C write per issue cycle, two cycles later.
- Reset mid-operation: immediate return to IDLE. Outputs drop to 0, no done_o is produced, and pending pipeline writes are discarded.
- busy_o=1 exactly while state is RUN or DRAIN.

Test Plan:
- M=K=N=2, start at t0:
  - A addresses t0+1..t0+8 = 0,1,0,1,2,3,2,3.
  - B addresses = 0,2,1,3,0,2,1,3.
  - mac_clr_o on t0+2,4,6,8.
  - C writes at t0+4,6,8,10 with addresses 0,1,2,3.
  - done_o at t0+11.
- M=K=N=1: single issue at t0+1 with addresses A=0, B=0. mac_en_o and mac_clr_o at t0+2; C write to address 0 at t0+3; done_o at t0+4.
- M=3, K=0, N=4: done_o at t0+1. busy_o, mac_en_o and sram_c_we_o never assert.
- M=4, K=3, N=5:
  - Pulse start_i again at t0+10 and change sizes to 1 mid-run. Both are ignored.
  - Exactly 20 C writes to addresses 0..19 in order; done_o at t0+63.
  - Products checked against a golden model with random int8 data.
- M=K=N=8: deassert rst_ni at t0+100 for 2 cycles. All outputs go to 0 asynchronously with no done_o. A new 2x2x2 start then completes identically to the first scenario.
- Back-to-back runs: start held high continuously. A new run is accepted on the cycle after done_o, and sizes are re-latched per run.
